// File: rtl/countdown_display_ctrl.sv
// Countdown game timer controller: a 15 s / 9 s countdown state machine,
// a 1 Hz tick divider, a fail flag and a two-digit active-low
// seven-segment display scan.
module countdown_display_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       fail,
  output logic [3:0] count,
  output logic [1:0] state
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_FAIL  = 2'b11
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    count_r, count_nxt_s;
  logic [TW-1:0] tick_cnt_r, tick_nxt_s;
  logic [SW-1:0] scan_cnt_r;
  logic          digit_sel_r;
  logic          start_q_r;
  logic          fail_r;
  logic [6:0]    seg_r;
  logic [3:0]    an_r;

  logic          start_edge_s;
  logic          tick_s;
  logic [3:0]    start_val_s;
  logic          tens_s;
  logic [3:0]    units_s;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  assign start_edge_s = start & ~start_q_r;
  assign start_val_s  = mode ? 4'd9 : 4'd15;
  assign tick_s       = (state_r == ST_RUN) && (tick_cnt_r == TICK_LAST);
  assign tens_s       = (count_r >= 4'd10);
  assign units_s      = tens_s ? (count_r - 4'd10) : count_r;

  // Next-state, next-count and tick divider logic; a start edge wins over pause and tick.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    tick_nxt_s  = tick_cnt_r;
    case (state_r)
      ST_IDLE: begin
        count_nxt_s = start_val_s;
        if (start_edge_s) begin
          state_nxt_s = ST_RUN;
          tick_nxt_s  = {TW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_edge_s) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = start_val_s;
          tick_nxt_s  = {TW{1'b0}};
        end else if (tick_s) begin
          tick_nxt_s = {TW{1'b0}};
          if (count_r <= 4'd1) begin
            count_nxt_s = 4'd0;
            state_nxt_s = ST_FAIL;
          end else begin
            count_nxt_s = count_r - 4'd1;
            state_nxt_s = pause ? ST_PAUSE : ST_RUN;
          end
        end else begin
          tick_nxt_s  = tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
          state_nxt_s = pause ? ST_PAUSE : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start_edge_s) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = start_val_s;
          tick_nxt_s  = {TW{1'b0}};
        end else if (!pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_FAIL: begin
        if (start_edge_s) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = start_val_s;
          tick_nxt_s  = {TW{1'b0}};
        end else begin
          state_nxt_s = ST_FAIL;
          count_nxt_s = 4'd0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = 4'd0;
        tick_nxt_s  = {TW{1'b0}};
      end
    endcase
  end

  // Controller state register; fail follows the next state so it rises with FAIL.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 4'd0;
      tick_cnt_r <= {TW{1'b0}};
      start_q_r  <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      tick_cnt_r <= tick_nxt_s;
      start_q_r  <= start;
      fail_r     <= (state_nxt_s == ST_FAIL);
    end
  end

  // Free-running digit scan counter toggling the selected digit each slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_r  <= {SW{1'b0}};
      digit_sel_r <= 1'b0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r  <= {SW{1'b0}};
      digit_sel_r <= ~digit_sel_r;
    end else begin
      scan_cnt_r  <= scan_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Registered segment and anode drive; a leading zero tens digit is blanked.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_r <= 7'b1111111;
      an_r  <= 4'b1111;
    end else if (digit_sel_r) begin
      an_r  <= 4'b1101;
      seg_r <= tens_s ? seg7(4'd1) : 7'b1111111;
    end else begin
      an_r  <= 4'b1110;
      seg_r <= seg7(units_s);
    end
  end

  assign seg   = seg_r;
  assign an    = an_r;
  assign fail  = fail_r;
  assign count = count_r;
  assign state = state_r;

endmodule
